// File: rtl/sa_clkgate_pkg.sv
// Shared constants for the clock-gate enable controller: FSM encoding and wake counter sizing.
// No logic; imported by sa_clkgate_ctrl.
package sa_clkgate_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        OFF  = 2'd1,
        WAKE = 2'd2
    } state_e;

    localparam int WAKE_LAT_DEF = 2;
    localparam int WAKE_CNT_W   = 4;

endpackage

// File: rtl/sa_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count visible one edge after inc. Backpressure: none, holds at all-ones.
// Used for the idle run length and the gated-cycle statistic.
module sa_sat_counter #(
    parameter int W = 8
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_q
);

    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sa_clkgate_ctrl.sv
// Enable-side controller for a latch-based clock gate: gates after a programmable idle run, re-enables on wake.
// Latency: clk_en registered (one edge); wake_ack rises WAKE_LAT edges after the waking edge.
// Backpressure: wake_req is a level held until wake_ack. Optional gated_cnt port under SA_CLKGATE_STATS_EN.
module sa_clkgate_ctrl
    import sa_clkgate_pkg::*;
#(
    parameter int IDLE_W   = 8,
    parameter int WAKE_LAT = WAKE_LAT_DEF
`ifdef SA_CLKGATE_STATS_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic [IDLE_W-1:0] cfg_idle_thresh,
    input  logic              cfg_force_on,
    input  logic              test_mode,
    input  logic              unit_busy,
    input  logic              wake_req,
    output logic              wake_ack,
    output logic              clk_en,
    output logic              clk_te
`ifdef SA_CLKGATE_STATS_EN
    ,
    output logic [CNT_W-1:0]  gated_cnt
`endif
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_LAT - 1);

    state_e                  state_q;
    state_e                  state_d;
    logic                    clk_en_q;
    logic                    clk_en_d;
    logic                    ack_en_q;
    logic                    ack_en_d;
    logic [WAKE_CNT_W-1:0]   wake_cnt_q;
    logic [WAKE_CNT_W-1:0]   wake_cnt_d;
    logic [IDLE_W-1:0]       idle_cnt_q;
    logic                    idle_vld;
    logic                    thresh_hit;
    logic                    wake_cond;
    logic                    idle_clr;
    logic                    idle_inc;

    assign idle_vld  = !unit_busy && !wake_req && !cfg_force_on && (cfg_idle_thresh != '0);
    // Extra bit so a saturated idle count plus one still compares as reaching any threshold.
    assign thresh_hit = ({1'b0, idle_cnt_q} + (IDLE_W+1)'(1)) >= {1'b0, cfg_idle_thresh};
    assign wake_cond = wake_req || unit_busy || cfg_force_on;

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_clr   = 1'b1;
        idle_inc   = 1'b0;
        case (state_q)
            RUN: begin
                idle_clr = !idle_vld;
                idle_inc = idle_vld;
                if (idle_vld && thresh_hit) begin
                    state_d = OFF;
                end
            end
            OFF: begin
                if (wake_cond) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = RUN;
                    wake_cnt_d = '0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        clk_en_d = (state_d != OFF);
        ack_en_d = 1'b1;
    end

    // ack_en_q keeps wake_ack low while reset is held even though the state register reads RUN.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= RUN;
            clk_en_q   <= 1'b1;
            ack_en_q   <= 1'b0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clk_en_q   <= clk_en_d;
            ack_en_q   <= ack_en_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    sa_sat_counter #(
        .W (IDLE_W)
    ) u_idle_cnt (
        .core_clk (nvdla_core_clk),
        .arst_n   (nvdla_core_rstn),
        .clr      (idle_clr),
        .inc      (idle_inc),
        .cnt_q    (idle_cnt_q)
    );

`ifdef SA_CLKGATE_STATS_EN
    sa_sat_counter #(
        .W (CNT_W)
    ) u_gated_cnt (
        .core_clk (nvdla_core_clk),
        .arst_n   (nvdla_core_rstn),
        .clr      (1'b0),
        .inc      (!clk_en_q),
        .cnt_q    (gated_cnt)
    );
`endif

    assign clk_en   = clk_en_q;
    assign clk_te   = test_mode;
    assign wake_ack = (state_q == RUN) && wake_req && ack_en_q;

endmodule

// File: tb/tb_sa_clkgate_ctrl.sv
// Self-checking bench for sa_clkgate_ctrl: hand-computed vector table, corner sequences, random run vs model.
module tb_sa_clkgate_ctrl;

    localparam int WAKE_LAT = 2;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rstn;
    logic [7:0]  cfg_idle_thresh;
    logic        cfg_force_on;
    logic        test_mode;
    logic        unit_busy;
    logic        wake_req;
    logic        wake_ack;
    logic        clk_en;
    logic        clk_te;
`ifdef SA_CLKGATE_STATS_EN
    logic [31:0] gated_cnt;
    logic [3:0]  gated_cnt4;
    logic        wake_ack4;
    logic        clk_en4;
    logic        clk_te4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    sa_clkgate_ctrl dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .cfg_idle_thresh (cfg_idle_thresh),
        .cfg_force_on    (cfg_force_on),
        .test_mode       (test_mode),
        .unit_busy       (unit_busy),
        .wake_req        (wake_req),
        .wake_ack        (wake_ack),
        .clk_en          (clk_en),
        .clk_te          (clk_te)
`ifdef SA_CLKGATE_STATS_EN
        ,
        .gated_cnt       (gated_cnt)
`endif
    );

`ifdef SA_CLKGATE_STATS_EN
    sa_clkgate_ctrl #(.CNT_W(4)) dut4 (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .cfg_idle_thresh (cfg_idle_thresh),
        .cfg_force_on    (cfg_force_on),
        .test_mode       (test_mode),
        .unit_busy       (unit_busy),
        .wake_req        (wake_req),
        .wake_ack        (wake_ack4),
        .clk_en          (clk_en4),
        .clk_te          (clk_te4),
        .gated_cnt       (gated_cnt4)
    );
`endif

    // Behavioural model: gated flag, cycles left before the clock counts as running, idle run length.
    bit      m_gated;
    int      m_wake_left;
    int      m_run;
    bit      m_live;
    longint  m_gcnt;

    task automatic model_reset();
        m_gated     = 1'b0;
        m_wake_left = 0;
        m_run       = 0;
        m_live      = 1'b0;
        m_gcnt      = 0;
    endtask

    task automatic model_edge();
        bit idle;
        idle = !unit_busy && !wake_req && !cfg_force_on && (cfg_idle_thresh != 0);
        if (m_gated) m_gcnt++;
        m_live = 1'b1;
        if (m_gated) begin
            if (wake_req || unit_busy || cfg_force_on) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_LAT;
                m_run       = 0;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            m_run = 0;
        end else if (idle) begin
            m_run++;
            if (m_run >= int'(cfg_idle_thresh)) m_gated = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        logic exp_ack;
        exp_ack = m_live && !m_gated && (m_wake_left == 0) && wake_req;
        chk1($sformatf("rnd%0d_clk_en", cyc), clk_en, !m_gated);
        chk1($sformatf("rnd%0d_wake_ack", cyc), wake_ack, exp_ack);
        chk1($sformatf("rnd%0d_clk_te", cyc), clk_te, test_mode);
`ifdef SA_CLKGATE_STATS_EN
        chkn($sformatf("rnd%0d_gated_cnt", cyc), longint'(gated_cnt), m_gcnt);
        chkn($sformatf("rnd%0d_gated_cnt4", cyc), longint'(gated_cnt4), (m_gcnt > 15) ? 15 : m_gcnt);
`endif
    endtask

    task automatic do_reset(input string tag);
        nvdla_core_rstn = 1'b0;
        #1;
        model_reset();
        chk1({tag, "_clk_en"}, clk_en, 1'b1);
        chk1({tag, "_wake_ack"}, wake_ack, 1'b0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [7:0] thresh;
        logic [3:0] in;   // {force_on, busy, wake_req, test_mode}
        logic [2:0] exp;  // {clk_en, wake_ack, clk_te} after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [7:0] th, input logic [3:0] in, input logic [2:0] exp);
        vec_t v;
        v.thresh = th;
        v.in     = in;
        v.exp    = exp;
        tbl.push_back(v);
    endtask

    initial begin
        int off_cnt;
        nvdla_core_rstn = 1'b1;
        cfg_idle_thresh = 8'd4;
        cfg_force_on    = 1'b0;
        test_mode       = 1'b0;
        unit_busy       = 1'b0;
        wake_req        = 1'b0;
        model_reset();

        // Idle run gates after the 4th idle edge, wake, re-gate, DFT, force_on, thresh 0.
        for (int i = 0; i < 3; i++) add_vec(8'd4, 4'b0000, 3'b100);
        add_vec(8'd4, 4'b0000, 3'b000);
        add_vec(8'd4, 4'b0000, 3'b000);
        add_vec(8'd4, 4'b0010, 3'b100);
        add_vec(8'd4, 4'b0010, 3'b100);
        add_vec(8'd4, 4'b0010, 3'b110);
        for (int i = 0; i < 3; i++) add_vec(8'd4, 4'b0000, 3'b100);
        add_vec(8'd4, 4'b0000, 3'b000);
        add_vec(8'd4, 4'b0001, 3'b001);
        for (int i = 0; i < 3; i++) add_vec(8'd4, 4'b1000, 3'b100);
        for (int i = 0; i < 3; i++) add_vec(8'd0, 4'b0000, 3'b100);
        // Busy on idle edge 3 restarts the run; gating 4 edges after busy falls.
        add_vec(8'd4, 4'b0000, 3'b100);
        add_vec(8'd4, 4'b0000, 3'b100);
        add_vec(8'd4, 4'b0100, 3'b100);
        for (int i = 0; i < 3; i++) add_vec(8'd4, 4'b0000, 3'b100);
        add_vec(8'd4, 4'b0000, 3'b000);
        add_vec(8'd4, 4'b0010, 3'b100);
        add_vec(8'd4, 4'b0010, 3'b100);
        add_vec(8'd4, 4'b0010, 3'b110);
        // wake_req on the edge that would reach the threshold keeps the clock on.
        for (int i = 0; i < 3; i++) add_vec(8'd4, 4'b0000, 3'b100);
        add_vec(8'd4, 4'b0010, 3'b110);
        add_vec(8'd4, 4'b0000, 3'b100);

        #1;
        do_reset("rst_init");

        foreach (tbl[i]) begin
            cfg_idle_thresh = tbl[i].thresh;
            {cfg_force_on, unit_busy, wake_req, test_mode} = tbl[i].in;
            tick();
            chk1($sformatf("vec%0d_clk_en", i), clk_en, tbl[i].exp[2]);
            chk1($sformatf("vec%0d_wake_ack", i), wake_ack, tbl[i].exp[1]);
            chk1($sformatf("vec%0d_clk_te", i), clk_te, tbl[i].exp[0]);
        end

        // wake_req raised in RUN acks without an edge and restarts the idle run.
        wake_req = 1'b1;
        #1;
        chk1("run_ack_same_cycle", wake_ack, 1'b1);
        tick();
        wake_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk1("run_idle3_clk_en", clk_en, 1'b1);
        tick();
        chk1("run_idle4_clk_en", clk_en, 1'b0);

        // Reset while OFF, with wake_req already up.
        wake_req = 1'b1;
        #1;
        chk1("off_no_ack", wake_ack, 1'b0);
        do_reset("rst_in_off");
        tick();
        chk1("post_rst_ack", wake_ack, 1'b1);

        // Reset while WAKE.
        wake_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk1("regate_clk_en", clk_en, 1'b0);
        wake_req = 1'b1;
        tick();
        chk1("wake_clk_en", clk_en, 1'b1);
        chk1("wake_no_ack", wake_ack, 1'b0);
        do_reset("rst_in_wake");
        wake_req = 1'b0;

        // Threshold lowered below the current run gates on the next idle edge.
        cfg_idle_thresh = 8'd10;
        for (int i = 0; i < 5; i++) tick();
        chk1("thresh10_clk_en", clk_en, 1'b1);
        cfg_idle_thresh = 8'd3;
        tick();
        chk1("thresh_lowered_clk_en", clk_en, 1'b0);

        // force_on from OFF wakes and holds the clock; thresh 0 holds it too.
        cfg_force_on = 1'b1;
        off_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clk_en !== 1'b1) off_cnt++;
        end
        chkn("force_on_off_cycles", off_cnt, 0);
        cfg_force_on    = 1'b0;
        cfg_idle_thresh = 8'd0;
        off_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clk_en !== 1'b1) off_cnt++;
        end
        chkn("thresh0_off_cycles", off_cnt, 0);

`ifdef SA_CLKGATE_STATS_EN
        cfg_idle_thresh = 8'd2;
        do_reset("rst_stats");
        for (int i = 0; i < 20; i++) tick();
        chkn("gated_cnt_20", longint'(gated_cnt), 18);
        chkn("gated_cnt4_sat", longint'(gated_cnt4), 15);
`endif

        // Random traffic against the model.
        cfg_idle_thresh = 8'd3;
        do_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 5))
                    0: cfg_idle_thresh = 8'd0;
                    1: cfg_idle_thresh = 8'd1;
                    2: cfg_idle_thresh = 8'd2;
                    3: cfg_idle_thresh = 8'd3;
                    4: cfg_idle_thresh = 8'd6;
                    default: cfg_idle_thresh = 8'($urandom_range(0, 20));
                endcase
            end
            unit_busy    = ($urandom_range(0, 7) == 0);
            cfg_force_on = ($urandom_range(0, 63) == 0);
            test_mode    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 11) == 0) wake_req = ~wake_req;
            #1;
            check_model(i);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_clkgate_ctrl.md
Name: sa_clkgate_ctrl

Overview:
- Enable-side controller for the latch-based clock-gate cell. It drives the cell's E and TE inputs.
- Watches unit activity and gates the clock after a programmable run of idle cycles.
- Re-enables the clock on a wake request and acknowledges once the clock has been running for a fixed latency.
- Runs on the free-running core clock; one instance per gated unit.

Parameters:
- IDLE_W, 8: width of the idle threshold and the idle counter.
- WAKE_LAT, 2: cycles the clock runs in WAKE before wake_ack may assert; legal range 1..15.
- CNT_W, 32: width of the gated-cycle statistics counter (optional feature only).

Ports:
- nvdla_core_clk  in  1  free-running core clock.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- cfg_idle_thresh  in  IDLE_W  consecutive idle cycles before gating; 0 disables gating (clock always on).
- cfg_force_on  in  1  software override; keeps the clock on.
- test_mode  in  1  DFT scan mode.
- unit_busy  in  1  gated unit reports work in flight.
- wake_req  in  1  requester needs the gated unit; level, held until wake_ack.
- wake_ack  out  1  gated clock is stable; the request may proceed.
- clk_en  out  1  to the gate cell's E input; registered.
- clk_te  out  1  to the gate cell's TE input.
- gated_cnt  out  CNT_W  cycles spent gated; present only with the optional feature.

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous, active-low.
- Reset values:
  - state=RUN, clk_en=1 (the unit sees its clock during reset), wake_ack=0.
  - idle_cnt=0, wake_cnt=0, gated_cnt=0.
  - Reset asserted mid-operation returns immediately to these values, including from OFF or WAKE.
- Idle condition: idle = !unit_busy & !wake_req & !cfg_force_on & (cfg_idle_thresh!=0).
- State RUN (clk_en=1):
  - Each edge with idle: idle_cnt increments, saturating at all-ones.
  - Each edge without idle: idle_cnt clears to 0.
  - Edge where idle is sampled and idle_cnt+1 >= cfg_idle_thresh: go to OFF and set clk_en=0.
  - Example, threshold 4: idle sampled on edges k..k+3 gives clk_en low after edge k+3.
- State OFF (clk_en=0):
  - Edge sampling wake_req | unit_busy | cfg_force_on: go to WAKE, clk_en=1 after that edge, wake_cnt=0.
- State WAKE (clk_en=1):
  - wake_cnt increments each edge.
  - On the edge where wake_cnt==WAKE_LAT-1: go to RUN with idle_cnt=0.
  - wake_req dropping during WAKE does not abort; the block still returns to RUN.
- wake_ack = (state==RUN) & wake_req; combinational from the state register.
  - Wake from OFF: ack visible WAKE_LAT cycles after the waking edge.
  - wake_req raised while in RUN: ack in the same cycle, and idle_cnt clears.
- clk_te = test_mode, combinational; this is the only combinational path to the gate cell.
  - test_mode does not alter the FSM.
- Threshold changed mid-count: the comparison uses the current value. A lowered threshold at or below idle_cnt gates on the next idle edge.
- Simultaneous events: wake_req on the same edge the threshold is reached means idle=0, so the block stays in RUN.
- clk_en is glitch-free: a flop output only.

Optional Feature:
- Macro SA_CLKGATE_STATS_EN.
- Defined: gated_cnt port exists. It increments on every edge where registered clk_en==0 and saturates at all-ones. It clears only on reset.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package sa_clkgate_pkg holds:
  - the state encoding: RUN=2'd0, OFF=2'd1, WAKE=2'd2;
  - the default WAKE_LAT constant;
  - the localparam for the wake_cnt width (4).
- One sub-module, sa_sat_counter (parameterised width; clear, increment, saturate). It is instantiated for idle_cnt and for gated_cnt.

Test Plan:
- Reset, then thresh=4 with busy=0 and wake_req=0 for 10 cycles: clk_en=1 through edge 3, 0 after edge 4 counting from the first idle edge; wake_ack=0.
- In OFF, raise wake_req: clk_en=1 after the next edge; wake_ack=1 exactly 2 cycles later (WAKE_LAT=2); drop wake_req, and after 4 further idle edges clk_en=0.
- thresh=0, or cfg_force_on=1 at any time: clk_en stays 1 for 100 cycles; force_on asserted while OFF wakes the clock.
- busy pulse on idle edge 3 of 4: idle_cnt clears, no gating; gating occurs 4 edges after busy falls.
- Assert rstn low while in WAKE and while in OFF: clk_en=1 and wake_ack=0 immediately, without a clock edge.
- With SA_CLKGATE_STATS_EN and thresh=2, hold idle for 20 cycles: gated_cnt=18; with width forced to 4, gated_cnt saturates at 15.
